// File: rtl/alu_arbiter_pkg.sv
// Shared ALU-arbiter definitions: op codes, FSM encodings and latched request context.
package k6502_defs;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 8;

  localparam logic [OP_W-1:0] OP_INC          = 4'h3;
  localparam logic [OP_W-1:0] IDLE_OP_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  // Fields of the granted request kept for the remainder of the operation.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] sel_hi;
    logic             wide;
  } req_ctx_t;

  // Index width for an n-entry requester set (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after the pointer, wrapping.
module rr_pick
  import k6502_defs::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_oh_c_o,
  output logic [IW-1:0]   win_idx_c_o,
  output logic            any_c_o
);

  logic [IW:0] cand;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    win_oh_c_o  = '0;
    win_idx_c_o = '0;
    any_c_o     = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!any_c_o && req_i[cand[IW-1:0]]) begin
        any_c_o     = 1'b1;
        win_idx_c_o = cand[IW-1:0];
      end
    end
    if (any_c_o) begin
      win_oh_c_o = NREQ'(1) << win_idx_c_o;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between NREQ requesters; sequences 16-bit increments as two byte passes.
module alu_arbiter
  import k6502_defs::*;
#(
  parameter int unsigned     NREQ    = 2,
  parameter logic [OP_W-1:0] IDLE_OP = IDLE_OP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [OP_W*NREQ-1:0]   req_op,
  input  logic [SEL_W*NREQ-1:0]  req_sel_lo,
  input  logic [SEL_W*NREQ-1:0]  req_sel_hi,
  input  logic [NREQ-1:0]        req_wide,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      result_lo,
  output logic [DATA_W-1:0]      result_hi,
  output logic                   hi_updated,
  output logic                   result_carry,
  output logic                   busy,
  output logic [OP_W-1:0]        alu_op,
  output logic [SEL_W-1:0]       alu_arg_sel,
  input  logic [DATA_W-1:0]      alu_data_out
);

  localparam int unsigned IW = idx_width(NREQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  req_ctx_t          ctx_q, ctx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic              hi_upd_q, hi_upd_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              finish;

  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .win_oh_c_o  (win_oh),
    .win_idx_c_o (win_idx),
    .any_c_o     (win_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    ctx_d     = ctx_q;
    gnt_d     = '0;
    done_d    = '0;
    alu_op_d  = alu_op_q;
    alu_sel_d = alu_sel_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    hi_upd_d  = hi_upd_q;
    carry_d   = carry_q;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        alu_op_d  = IDLE_OP;
        alu_sel_d = '0;
        if (win_any) begin
          gnt_d        = win_oh;
          alu_op_d     = req_op[{win_idx, 2'b00} +: OP_W];
          alu_sel_d    = req_sel_lo[{win_idx, 1'b0} +: SEL_W];
          ctx_d.op     = req_op[{win_idx, 2'b00} +: OP_W];
          ctx_d.sel_hi = req_sel_hi[{win_idx, 1'b0} +: SEL_W];
          ctx_d.wide   = req_wide[win_idx] &&
                         (req_op[{win_idx, 2'b00} +: OP_W] == OP_INC);
          owner_d      = win_idx;
          ptr_d        = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
          state_d      = ST_LO;
        end
      end
      ST_LO: begin
        res_lo_d = alu_data_out;
        hi_upd_d = 1'b0;
        carry_d  = 1'b0;
        if ((ctx_q.op == OP_INC) && (alu_data_out == '0)) begin
          if (ctx_q.wide) begin
            alu_sel_d = ctx_q.sel_hi;
            state_d   = ST_HI;
          end else begin
            carry_d = 1'b1;
            finish  = 1'b1;
          end
        end else begin
          finish = 1'b1;
        end
      end
      ST_HI: begin
        res_hi_d = alu_data_out;
        hi_upd_d = 1'b1;
        carry_d  = (alu_data_out == '0);
        finish   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      done_d    = NREQ'(1) << owner_q;
      alu_op_d  = IDLE_OP;
      alu_sel_d = '0;
      state_d   = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      ctx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      alu_op_q  <= IDLE_OP;
      alu_sel_q <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      hi_upd_q  <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      ctx_q     <= ctx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      alu_op_q  <= alu_op_d;
      alu_sel_q <= alu_sel_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      hi_upd_q  <= hi_upd_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign alu_op       = alu_op_q;
  assign alu_arg_sel  = alu_sel_q;
  assign result_lo    = res_lo_q;
  assign result_hi    = res_hi_q;
  assign hi_updated   = hi_upd_q;
  assign result_carry = carry_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a simple falling-edge ALU model.
module tb_alu_arbiter;
  import k6502_defs::*;

  localparam int unsigned NREQ = 2;
  localparam logic [3:0] OP_PASS = 4'h0;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [4*NREQ-1:0] req_op;
  logic [2*NREQ-1:0] req_sel_lo;
  logic [2*NREQ-1:0] req_sel_hi;
  logic [NREQ-1:0] req_wide;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [7:0]      result_lo;
  logic [7:0]      result_hi;
  logic            hi_updated;
  logic            result_carry;
  logic            busy;
  logic [3:0]      alu_op;
  logic [1:0]      alu_arg_sel;
  logic [7:0]      alu_data_out;

  int n_checks;
  int n_fail;

  // ALU model: latches op/arg_sel on the falling edge; INC adds one, anything else passes the arg.
  logic [7:0] arg_mem [4];
  logic [3:0] lat_op;
  logic [1:0] lat_sel;

  always @(negedge clk) begin
    lat_op  <= alu_op;
    lat_sel <= alu_arg_sel;
  end

  assign alu_data_out = (lat_op == OP_INC) ? 8'(arg_mem[lat_sel] + 8'd1) : arg_mem[lat_sel];

  alu_arbiter #(
    .NREQ    (NREQ),
    .IDLE_OP (4'hF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_op       (req_op),
    .req_sel_lo   (req_sel_lo),
    .req_sel_hi   (req_sel_hi),
    .req_wide     (req_wide),
    .gnt          (gnt),
    .done         (done),
    .result_lo    (result_lo),
    .result_hi    (result_hi),
    .hi_updated   (hi_updated),
    .result_carry (result_carry),
    .busy         (busy),
    .alu_op       (alu_op),
    .alu_arg_sel  (alu_arg_sel),
    .alu_data_out (alu_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int r, input logic [3:0] op, input logic [1:0] slo,
                            input logic [1:0] shi, input logic w);
    req_op[4*r +: 4]     = op;
    req_sel_lo[2*r +: 2] = slo;
    req_sel_hi[2*r +: 2] = shi;
    req_wide[r]          = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks++; if (alu_op !== 4'hF) begin n_fail++; $display("FAIL reset_alu_op: got %h want %h", alu_op, 4'hF); end
    n_checks++; if (gnt !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_done: got gnt=%b done=%b want 00/00", gnt, done); end
    n_checks++; if ({busy, hi_updated, result_carry} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, hi_updated, result_carry}); end
    n_checks++; if ({result_lo, result_hi, alu_arg_sel} !== 18'h0) begin n_fail++; $display("FAIL reset_results: got lo=%h hi=%h sel=%h want 0", result_lo, result_hi, alu_arg_sel); end
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    n_checks++; if (alu_op !== 4'hF || busy !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL idle_no_req: got op=%h busy=%b gnt=%b want F/0/00", alu_op, busy, gnt); end
  endtask

  task automatic test_narrow();
    arg_mem[0] = 8'h41;
    set_fields(0, OP_INC, 2'd0, 2'd0, 1'b0);
    req = 2'b01;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL narrow_gnt: got %b want 01", gnt); end
    n_checks++; if (alu_op !== OP_INC || alu_arg_sel !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL narrow_drive: got op=%h sel=%h busy=%b", alu_op, alu_arg_sel, busy); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b01 || gnt !== 2'b00) begin n_fail++; $display("FAIL narrow_done: got done=%b gnt=%b want 01/00", done, gnt); end
    n_checks++; if (result_lo !== 8'h42 || result_carry !== 1'b0 || hi_updated !== 1'b0) begin n_fail++; $display("FAIL narrow_result: got lo=%h c=%b hu=%b want 42/0/0", result_lo, result_carry, hi_updated); end
    n_checks++; if (alu_op !== 4'hF || busy !== 1'b0) begin n_fail++; $display("FAIL narrow_idle: got op=%h busy=%b want F/0", alu_op, busy); end
    tick();
    n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL narrow_done_pulse: got %b want 00", done); end
  endtask

  task automatic test_wide();
    arg_mem[1] = 8'hFF;
    arg_mem[2] = 8'h12;
    set_fields(1, OP_INC, 2'd1, 2'd2, 1'b1);
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10 || alu_arg_sel !== 2'd1) begin n_fail++; $display("FAIL wide_gnt: got gnt=%b sel=%h want 10/1", gnt, alu_arg_sel); end
    req = 2'b00;
    tick();
    n_checks++; if (alu_arg_sel !== 2'd2 || alu_op !== OP_INC || busy !== 1'b1 || done !== 2'b00) begin n_fail++; $display("FAIL wide_hi_phase: got sel=%h op=%h busy=%b done=%b", alu_arg_sel, alu_op, busy, done); end
    n_checks++; if (result_lo !== 8'h00) begin n_fail++; $display("FAIL wide_lo: got %h want 00", result_lo); end
    tick();
    n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL wide_done: got %b want 10", done); end
    n_checks++; if (result_hi !== 8'h13 || hi_updated !== 1'b1 || result_carry !== 1'b0 || result_lo !== 8'h00) begin n_fail++; $display("FAIL wide_result: got lo=%h hi=%h hu=%b c=%b want 00/13/1/0", result_lo, result_hi, hi_updated, result_carry); end
    tick();
  endtask

  task automatic test_reset_mid();
    arg_mem[0] = 8'hFF;
    arg_mem[3] = 8'h55;
    set_fields(0, OP_INC, 2'd0, 2'd3, 1'b1);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    n_checks++; if (busy !== 1'b1 || alu_arg_sel !== 2'd3) begin n_fail++; $display("FAIL rmid_in_hi: got busy=%b sel=%h want 1/3", busy, alu_arg_sel); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (alu_op !== 4'hF || busy !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL rmid_async: got op=%h busy=%b done=%b want F/0/00", alu_op, busy, done); end
    n_checks++; if (result_lo !== 8'h00 || result_hi !== 8'h00 || hi_updated !== 1'b0 || result_carry !== 1'b0) begin n_fail++; $display("FAIL rmid_results: got lo=%h hi=%h hu=%b c=%b want 0", result_lo, result_hi, hi_updated, result_carry); end
    tick();
    n_checks++; if (done !== 2'b00 || alu_op !== 4'hF) begin n_fail++; $display("FAIL rmid_no_done: got done=%b op=%h want 00/F", done, alu_op); end
    #2 reset = 1'b0;
    tick();
    n_checks++; if (done !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got done=%b busy=%b want 00/0", done, busy); end
  endtask

  task automatic test_wide_ffff();
    arg_mem[0] = 8'hFF;
    arg_mem[3] = 8'hFF;
    set_fields(0, OP_INC, 2'd0, 2'd3, 1'b1);
    req = 2'b01;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL ffff_gnt: got %b want 01", gnt); end
    req = 2'b00;
    tick(); tick();
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL ffff_done: got %b want 01", done); end
    n_checks++; if (result_lo !== 8'h00 || result_hi !== 8'h00 || result_carry !== 1'b1 || hi_updated !== 1'b1) begin n_fail++; $display("FAIL ffff_result: got lo=%h hi=%h c=%b hu=%b want 00/00/1/1", result_lo, result_hi, result_carry, hi_updated); end
    tick();
  endtask

  task automatic test_wide_nowrap();
    arg_mem[1] = 8'h7F;
    set_fields(1, OP_INC, 2'd1, 2'd2, 1'b1);
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL nowrap_gnt: got %b want 10", gnt); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b10 || busy !== 1'b0) begin n_fail++; $display("FAIL nowrap_done: got done=%b busy=%b want 10/0", done, busy); end
    n_checks++; if (result_lo !== 8'h80 || hi_updated !== 1'b0 || result_carry !== 1'b0) begin n_fail++; $display("FAIL nowrap_result: got lo=%h hu=%b c=%b want 80/0/0", result_lo, hi_updated, result_carry); end
    n_checks++; if (result_hi !== 8'h00) begin n_fail++; $display("FAIL nowrap_hi_hold: got %h want 00", result_hi); end
    tick();
  endtask

  task automatic test_narrow_wrap();
    arg_mem[0] = 8'hFF;
    set_fields(0, OP_INC, 2'd0, 2'd3, 1'b0);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL nwrap_done: got %b want 01", done); end
    n_checks++; if (result_lo !== 8'h00 || result_carry !== 1'b1 || hi_updated !== 1'b0) begin n_fail++; $display("FAIL nwrap_result: got lo=%h c=%b hu=%b want 00/1/0", result_lo, result_carry, hi_updated); end
    tick();
  endtask

  task automatic test_non_inc();
    arg_mem[1] = 8'hFF;
    set_fields(1, OP_PASS, 2'd1, 2'd2, 1'b1);
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10 || alu_op !== OP_PASS) begin n_fail++; $display("FAIL noninc_gnt: got gnt=%b op=%h want 10/0", gnt, alu_op); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL noninc_done: got %b want 10", done); end
    n_checks++; if (result_lo !== 8'hFF || result_carry !== 1'b0 || hi_updated !== 1'b0) begin n_fail++; $display("FAIL noninc_result: got lo=%h c=%b hu=%b want FF/0/0", result_lo, result_carry, hi_updated); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt;
    logic [1:0] exp_done;
    logic [3:0] exp_op;
    arg_mem[0] = 8'h10;
    arg_mem[1] = 8'h20;
    set_fields(0, OP_INC, 2'd0, 2'd0, 1'b0);
    set_fields(1, OP_INC, 2'd1, 2'd0, 1'b0);
    req = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_gnt  = ((c % 2) == 0) ? (((c % 4) == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_done = ((c % 2) == 1) ? (((c % 4) == 1) ? 2'b01 : 2'b10) : 2'b00;
      exp_op   = ((c % 2) == 1) ? 4'hF : OP_INC;
      n_checks++; if (gnt !== exp_gnt || done !== exp_done) begin n_fail++; $display("FAIL b2b_c%0d: got gnt=%b done=%b want %b/%b", c, gnt, done, exp_gnt, exp_done); end
      n_checks++; if (alu_op !== exp_op) begin n_fail++; $display("FAIL b2b_op_c%0d: got %h want %h", c, alu_op, exp_op); end
      if ((c % 2) == 1) begin
        n_checks++; if (result_lo !== (((c % 4) == 1) ? 8'h11 : 8'h21)) begin n_fail++; $display("FAIL b2b_res_c%0d: got %h", c, result_lo); end
      end
    end
    req = 2'b00;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_drain: got busy=%b gnt=%b want 0/00", busy, gnt); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req        = '0;
    req_op     = '0;
    req_sel_lo = '0;
    req_sel_hi = '0;
    req_wide   = '0;
    for (int i = 0; i < 4; i++) arg_mem[i] = 8'h00;

    test_reset();
    test_narrow();
    test_wide();
    test_reset_mid();
    test_wide_ffff();
    test_wide_nowrap();
    test_narrow_wrap();
    test_non_inc();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
